// File: rtl/vedic_mac_acc.sv
// Pipelined multiply-accumulate stage. Operand pairs arrive over a valid/ready
// handshake. Each pair is multiplied by a vedic_8X8 instance, and the products
// are summed over a frame ending at in_last. The frame total, the beat count
// and a sticky overflow flag are returned over a second valid/ready handshake.

// 2x2 Vedic multiplier cell built from gates.
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic w_c;
  assign w_c  = a[1] & b[0] & a[0] & b[1];
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2] = (a[1] & b[1]) ^ w_c;
  assign p[3] = (a[1] & b[1]) & w_c;
endmodule

// 4x4 Vedic multiplier: four 2x2 partial products, then a shifted sum.
module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] w_q0, w_q1, w_q2, w_q3;
  vedic_2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(w_q0));
  vedic_2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(w_q1));
  vedic_2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(w_q2));
  vedic_2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(w_q3));
  assign p = 8'(w_q0) + (8'(w_q1) << 2) + (8'(w_q2) << 2) + (8'(w_q3) << 4);
endmodule

// 8x8 Vedic multiplier: four 4x4 partial products, then a shifted sum.
module vedic_8X8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] prod
);
  logic [7:0] w_q0, w_q1, w_q2, w_q3;
  vedic_4x4 u_q0 (.a(a[3:0]), .b(b[3:0]), .p(w_q0));
  vedic_4x4 u_q1 (.a(a[7:4]), .b(b[3:0]), .p(w_q1));
  vedic_4x4 u_q2 (.a(a[3:0]), .b(b[7:4]), .p(w_q2));
  vedic_4x4 u_q3 (.a(a[7:4]), .b(b[7:4]), .p(w_q3));
  assign prod = 16'(w_q0) + (16'(w_q1) << 4) + (16'(w_q2) << 4) + (16'(w_q3) << 8);
endmodule

module vedic_mac_acc #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  localparam int unsigned SW = ACC_W + 1;

  typedef enum logic [1:0] {ACC = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_t;
  state_t r_state, w_next;

  logic [7:0]       r_s1_a, r_s1_b;
  logic             r_s1_last, r_s1_v;
  logic [15:0]      r_s2_p;
  logic             r_s2_last, r_s2_v;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [15:0]      w_prod;
  logic [SW-1:0]    w_sum;
  logic             w_accept, w_xfer;

  vedic_8X8 u_mul (.a(r_s1_a), .b(r_s1_b), .prod(w_prod));

  assign w_accept  = in_valid && in_ready && !clear;
  assign w_xfer    = out_valid && out_ready;
  assign w_sum     = {1'b0, r_acc} + SW'(r_s2_p);
  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      ACC: begin
        in_ready = 1'b1;
        if (w_accept && in_last) w_next = DRAIN;
      end
      DRAIN: if (r_s2_v && r_s2_last) w_next = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ACC;
      end
      default: w_next = ACC;
    endcase
    if (clear) w_next = ACC;
  end

  // Operand (S1) and product (S2) pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_a <= '0; r_s1_b <= '0; r_s1_last <= 1'b0; r_s1_v <= 1'b0;
      r_s2_p <= '0; r_s2_last <= 1'b0; r_s2_v <= 1'b0;
    end else begin
      r_s1_v    <= w_accept;
      r_s2_v    <= r_s1_v && !clear;
      r_s2_p    <= w_prod;
      r_s2_last <= r_s1_last;
      if (w_accept) begin
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
        r_s1_last <= in_last;
      end
    end
  end

  // Frame accumulator, saturating beat counter and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0; r_count <= '0; r_ovf <= 1'b0;
    end else if (clear || w_xfer) begin
      r_acc <= '0; r_count <= '0; r_ovf <= 1'b0;
    end else begin
      if (r_s2_v) begin
        r_acc <= w_sum[ACC_W-1:0];
        r_ovf <= r_ovf | w_sum[ACC_W];
      end
      if (w_accept && (r_count != '1)) r_count <= r_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_vedic_mac_acc.sv
// Self-checking bench for vedic_mac_acc. A behavioural model builds the
// expected frame results, which are queued as beats are sent and compared
// when the DUT presents out_valid.
module tb_vedic_mac_acc;
  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_acc;
  logic [7:0]  out_count;

  typedef struct packed {
    logic [23:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  res_t        sb[$];
  int          checks = 0, failures = 0;
  logic [23:0] m_acc = '0;
  logic [7:0]  m_cnt = '0;
  logic        m_ovf = 1'b0;

  vedic_mac_acc #(.ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_acc = '0; m_cnt = '0; m_ovf = 1'b0;
  endtask

  // Present one beat, wait (bounded) for acceptance, update the model.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    int unsigned waitc = 0;
    logic [15:0] p;
    logic [24:0] s;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1; waitc++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_beat_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    p = 16'(a) * 16'(b);
    s = {1'b0, m_acc} + {9'b0, p};
    m_acc = s[23:0];
    m_ovf = m_ovf | s[24];
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    if (last) begin
      sb.push_back('{acc: m_acc, cnt: m_cnt, ovf: m_ovf});
      model_reset();
    end
  endtask

  // Wait for a result, compare against the scoreboard, optionally stall, then hand it off.
  task automatic collect(input string name, input int unsigned stall);
    int unsigned waitc = 0;
    res_t exp;
    while (!out_valid && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL %s_out_valid_timeout: out_valid=%0b required 1", name, out_valid);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard_empty: queued=%0d required >0", name, sb.size());
      return;
    end
    exp = sb.pop_front();
    for (int unsigned c = 0; c <= stall; c++) begin
      checks++;
      if (out_acc !== exp.acc) begin
        failures++; $display("FAIL %s_acc: got %0d required %0d (cycle %0d)", name, out_acc, exp.acc, c);
      end
      checks++;
      if (out_count !== exp.cnt) begin
        failures++; $display("FAIL %s_count: got %0d required %0d (cycle %0d)", name, out_count, exp.cnt, c);
      end
      checks++;
      if (out_ovf !== exp.ovf) begin
        failures++; $display("FAIL %s_ovf: got %0b required %0b (cycle %0d)", name, out_ovf, exp.ovf, c);
      end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL %s_hold: out_valid=%0b in_ready=%0b required 1/0 (cycle %0d)", name, out_valid, in_ready, c);
      end
      if (c < stall) begin
        in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_last = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 24'd0 || out_count !== 8'd0) begin
      failures++;
      $display("FAIL %s_after_xfer: out_valid=%0b in_ready=%0b acc=%0d count=%0d required 0/1/0/0",
               name, out_valid, in_ready, out_acc, out_count);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 24'd0 || out_count !== 8'd0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b acc=%0d count=%0d ovf=%0b required 1/0/0/0/0",
               in_ready, out_valid, out_acc, out_count, out_ovf);
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    send_beat(8'd20, 8'd5, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL single_in_ready_k: got %0b required 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL single_k1: out_valid=%0b in_ready=%0b required 0/0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL single_k2_out_valid: got %0b required 1", out_valid);
    end
    collect("single", 0);
  endtask

  task automatic test_back_to_back();
    send_beat(8'd3, 8'd4, 1'b0);
    send_beat(8'd10, 8'd10, 1'b0);
    send_beat(8'd255, 8'd255, 1'b1);
    collect("b2b", 0);
    send_beat(8'd1, 8'd1, 1'b1);
    collect("b2b_next", 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 259; i++) send_beat(8'd255, 8'd255, (i == 258));
    collect("ovf259", 0);
    for (int i = 0; i < 258; i++) send_beat(8'd255, 8'd255, (i == 257));
    collect("ovf258", 0);
  endtask

  task automatic test_backpressure();
    send_beat(8'd12, 8'd34, 1'b0);
    send_beat(8'd56, 8'd78, 1'b1);
    collect("backpressure", 5);
  endtask

  task automatic test_clear();
    send_beat(8'd7, 8'd7, 1'b0);
    send_beat(8'd8, 8'd8, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    checks++;
    if (out_acc !== 24'd0 || out_count !== 8'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_flush: acc=%0d count=%0d in_ready=%0b required 0/0/1", out_acc, out_count, in_ready);
    end
    send_beat(8'd2, 8'd3, 1'b1);
    collect("clear", 0);
  endtask

  task automatic test_reset_drain();
    send_beat(8'd4, 8'd4, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 24'd0 || out_count !== 8'd0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_drain: in_ready=%0b out_valid=%0b acc=%0d count=%0d ovf=%0b required 1/0/0/0/0",
               in_ready, out_valid, out_acc, out_count, out_ovf);
    end
    sb.delete();
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    send_beat(8'd9, 8'd9, 1'b1);
    collect("reset_drain_next", 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_clear();
    test_reset_drain();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover: queued=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
